fifo_bit_serializer: RTL
========================

// Module: fifo_bit_serializer
// PURPOSE
//   Drains WIDTH-bit words from the 32x5 FIFO read port and emits them as a serial bit stream.
//   Uses a valid/ready handshake on the serial side.
//   Sits between the FIFO (upstream) and the serial sequence detectors (downstream).
//   FSM-driven: requests one word, captures it after the FIFO's 1-cycle read latency,
//   shifts it out bit by bit with an optional even-parity trailer, then repeats while data remains.
// PARAMETERS
//   WIDTH      5   word width; must match FIFO Width; legal range 1..16
//   MSB_FIRST  0   0: bit[0] sent first; 1: bit[WIDTH-1] sent first
//   PARITY_EN  0   1: append one even-parity bit (XOR of word) after the data bits
// PORTS
//   clk         in   1      single clock; all logic on posedge
//   rst         in   1      asynchronous, active-high reset
//   fifo_empty  in   1      FIFO empty flag (combinational from FIFO pointers)
//   fifo_rd_en  out  1      FIFO read request; registered, one cycle per word
//   fifo_data   in   WIDTH  FIFO data_out; valid the cycle after fifo_rd_en is high
//   bit_out     out  1      serial data bit
//   bit_valid   out  1      bit_out holds a bit to transfer
//   bit_ready   in   1      downstream accepts bit_out this cycle
//   word_done   out  1      one-cycle pulse when the final bit of a word (incl. parity) is accepted
//   busy        out  1      high in every state except IDLE
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE; shift register and bit counter cleared.
//     All outputs 0: fifo_rd_en, bit_out, bit_valid, word_done, busy.
//   - States are one-hot (IDLE, REQ, CAPT, SHIFT):
//       IDLE : if !fifo_empty go to REQ; otherwise stay.
//       REQ  : fifo_rd_en=1 for exactly this cycle, then go to CAPT.
//       CAPT : load shift register from fifo_data; load bit counter with WIDTH+PARITY_EN;
//              compute parity; go to SHIFT.
//       SHIFT: bit_valid=1. A transfer occurs on a cycle with bit_valid && bit_ready.
//              On each transfer the register shifts and the counter decrements.
//              On the last transfer, word_done=1 (registered, high the following cycle).
//              Next state is REQ if !fifo_empty, else IDLE.
//   - Handshake: while bit_valid && !bit_ready, bit_out and bit_valid hold stable.
//     bit_valid never drops without a transfer, except on reset.
//   - Throughput: with bit_ready tied high, a word costs WIDTH+PARITY_EN+2 cycles (REQ, CAPT, bits).
//     Back-to-back words have no IDLE gap.
//   - The parity bit equals ^word and is sent last, after all data bits, regardless of MSB_FIRST.
//   - fifo_empty is sampled only in IDLE and on the last SHIFT transfer; changes at other times are ignored.
//     The block is the FIFO's sole reader, so the FIFO cannot go empty between REQ and CAPT.
//   - fifo_rd_en is never asserted while fifo_empty=1.
//   - Reset mid-word discards the partial word; it is not retransmitted.
//   - WIDTH=1 with PARITY_EN=0 is legal: a single SHIFT transfer per word.
//   - An illegal state recovers to IDLE on the next clock.
// STRUCTURE
//   - Shared package/include fifo_ser_pkg: one-hot state localparams
//     IDLE=4'b0001, REQ=4'b0010, CAPT=4'b0100, SHIFT=4'b1000, plus the STATE_W=4 constant.
//   - One sub-module, ser_shift_reg: loadable WIDTH-bit shift register with bit counter and direction select.
//     The FSM, handshake and parity logic live in the top.
// TESTING
//   1. rst=1 mid-SHIFT -> all outputs 0 immediately (no clock needed); state IDLE after release.
//   2. WIDTH=5, MSB_FIRST=0, bit_ready=1, FIFO holds 5'b10110
//      -> fifo_rd_en pulses once; bits 0,1,1,0,1 on 5 consecutive cycles; word_done on the 5th; busy falls.
//   3. MSB_FIRST=1, PARITY_EN=1, word 5'b10110 -> bits 1,0,1,1,0 then parity 1; word_done after the 6th bit.
//   4. Backpressure: bit_ready low for 4 cycles during the 2nd bit
//      -> bit_out/bit_valid held stable; no bit lost or duplicated.
//   5. FIFO preloaded with 3 words, bit_ready=1 -> 3 fifo_rd_en pulses spaced 7 cycles apart; no IDLE between words.
//   6. End-to-end with the overlapping detector: push 5'b10110 (MSB_FIRST=1)
//      -> detector valid asserts exactly once, one cycle after the 5th bit.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared definitions for the FIFO bit serializer: one-hot FSM encoding and sizing helper.
package fifo_ser_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'b0001,
        REQ   = 4'b0010,
        CAPT  = 4'b0100,
        SHIFT = 4'b1000
    } state_e;

    // Bits needed to hold the value n.
    function automatic int unsigned bits_for(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register with a down-counting bit counter and selectable shift direction.
module ser_shift_reg #(
    parameter int unsigned WIDTH     = 5,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [CNT_W-1:0] cnt_init_i,
    input  logic             shift_i,
    output logic             bit_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = cnt_init_i;
        end else if (shift_i) begin
            sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_bit_serializer.sv
// Reads words from a 1-cycle-latency FIFO and streams them out bit-serially over valid/ready,
// with an optional trailing even-parity bit.
module fifo_bit_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 5,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int unsigned     NBITS    = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int unsigned     CNT_W    = bits_for(NBITS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NBITS);

    state_e           state_q;
    logic             rd_en_q;
    logic             valid_q;
    logic             done_q;
    logic             par_q;
    logic             sr_bit;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             last_xfer;
    logic             load;

    assign xfer      = valid_q & bit_ready_i;
    assign last_xfer = xfer & (cnt == CNT_W'(1));
    assign load      = (state_q == CAPT);

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_shift (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .data_i     (fifo_data_i),
        .cnt_init_i (CNT_INIT),
        .shift_i    (xfer),
        .bit_o      (sr_bit),
        .cnt_o      (cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_i) begin
                        state_q <= REQ;
                        rd_en_q <= 1'b1;
                    end
                end
                REQ: state_q <= CAPT;
                CAPT: begin
                    par_q   <= ^fifo_data_i;
                    valid_q <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // Chain straight into the next read so back-to-back words have no gap.
                    if (last_xfer) begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                        if (!fifo_empty_i) begin
                            state_q <= REQ;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The parity bit always occupies the final slot, whatever the shift direction.
    assign bit_out_o    = valid_q & ((PARITY_EN && cnt == CNT_W'(1)) ? par_q : sr_bit);
    assign bit_valid_o  = valid_q;
    assign fifo_rd_en_o = rd_en_q;
    assign word_done_o  = done_q;
    assign busy_o       = (state_q != IDLE);

endmodule
